// File: rtl/mole_pkg.sv
// Constants and per-channel debounce state type shared by the button
// conditioning block and the whack-a-mole game core.
package mole_pkg;

  localparam int N_MOLES = 9;
  localparam int CLK_HZ  = 50_000_000;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } deb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-flop synchronizer, stability-counting debounce FSM and
// registered level / press / release outputs.
module debounce_channel
  import mole_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17,
  parameter bit ACTIVE_HIGH     = 1'b1
) (
  input  logic cin,
  input  logic rst,
  input  logic raw,
  input  logic en,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d, s2_q, s2_d;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    // Polarity is normalised before the FSM so it only ever sees 1 = pressed.
    s1_d    = ACTIVE_HIGH ? raw : ~raw;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (s2_q) begin
          state_d = PRESS_PEND;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_PEND: begin
        if (!s2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = en;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = RELEASE_PEND;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_PEND: begin
        if (s2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          level_d = 1'b0;
          rel_d   = en;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

// File: rtl/mole_button_debounce.sv
// Debounces the nine mole buttons; btn_press is the game core's hit event,
// any_press flags a hit on any channel in the same cycle.
module mole_button_debounce
  import mole_pkg::*;
#(
  parameter int N_BTN           = N_MOLES,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17,
  parameter bit ACTIVE_HIGH     = 1'b1
) (
  input  logic             cin,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .ACTIVE_HIGH     (ACTIVE_HIGH)
    ) u_ch (
      .cin       (cin),
      .rst       (rst),
      .raw       (btn_raw[i]),
      .en        (en),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i])
    );
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_mole_button_debounce.sv
// Directed + random bench for the mole button debouncer against a
// sample-history reference model (D consecutive synced samples flip the level).
module tb_mole_button_debounce;

  localparam int N = 9;
  localparam int D = 4;

  logic         cin = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic         en;
  logic [N-1:0] btn_level, btn_press, btn_release;
  logic         any_press;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [N-1:0] d1, d2, m_level, m_press, m_rel;
  int           run [N];

  mole_button_debounce #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .CNT_W(17), .ACTIVE_HIGH(1'b1)
  ) dut (
    .cin(cin), .rst(rst), .btn_raw(btn_raw), .en(en),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .any_press(any_press)
  );

  always #5 cin = ~cin;

  task automatic model_reset();
    d1 = '0; d2 = '0; m_level = '0; m_press = '0; m_rel = '0;
    for (int c = 0; c < N; c++) run[c] = 0;
  endtask

  // Called right after each rising edge with the inputs that were applied.
  task automatic model_edge();
    logic [N-1:0] samp;
    if (rst) begin
      model_reset();
      return;
    end
    samp = d2;           // FSM sees raw from two edges ago
    d2   = d1;
    d1   = btn_raw;
    m_press = '0;
    m_rel   = '0;
    for (int c = 0; c < N; c++) begin
      if (samp[c] != m_level[c]) run[c]++;
      else                       run[c] = 0;
      if (run[c] == D) begin
        run[c] = 0;
        m_level[c] = ~m_level[c];
        if (m_level[c]) m_press[c] = en;
        else            m_rel[c]   = en;
      end
    end
  endtask

  task automatic check();
    n_assert++;
    assert (btn_level === m_level) else begin
      n_fail++; $error("FAIL level: got %h exp %h", btn_level, m_level);
    end
    n_assert++;
    assert (btn_press === m_press) else begin
      n_fail++; $error("FAIL press: got %h exp %h", btn_press, m_press);
    end
    n_assert++;
    assert (btn_release === m_rel) else begin
      n_fail++; $error("FAIL release: got %h exp %h", btn_release, m_rel);
    end
    n_assert++;
    assert (any_press === (|m_press)) else begin
      n_fail++; $error("FAIL any_press: got %b exp %b", any_press, |m_press);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge cin);
      model_edge();
      @(negedge cin);
      check();
    end
  endtask

  initial begin
    logic [6:0] bounce;
    rst = 1'b1; en = 1'b1; btn_raw = '0;
    model_reset();
    tick(3);
    rst = 1'b0;
    tick(3);

    // clean press on ch3: pulse exactly at the 6th edge after the rise
    btn_raw[3] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_assert++;
      assert (btn_press[3] === (k == 6)) else begin
        n_fail++; $error("FAIL latency3 edge %0d: got %b exp %b", k, btn_press[3], k == 6);
      end
    end

    // bounce on ch0: 1,1,0,1,1,1,0 then held
    bounce = 7'b0111011;
    for (int k = 0; k < 7; k++) begin
      btn_raw[0] = bounce[k];
      tick();
    end
    btn_raw[0] = 1'b1;
    tick(10);

    // releases
    btn_raw[3] = 1'b0;
    tick(10);
    btn_raw = '0;
    tick(10);

    // all channels at once
    btn_raw = '1;
    tick(10);
    btn_raw = '0;
    tick(10);

    // en gating on ch5: accepted while disabled, never replayed
    en = 1'b0;
    btn_raw[5] = 1'b1;
    tick(8);
    en = 1'b1;
    tick(5);
    btn_raw[5] = 1'b0;
    tick(8);

    // reset mid-pending on ch2, then a fresh full debounce
    btn_raw[2] = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    model_reset();
    check();
    tick(2);
    rst = 1'b0;
    tick(10);
    btn_raw[2] = 1'b0;
    tick(10);

    // toggling every cycle never pulses
    for (int k = 0; k < 30; k++) begin
      btn_raw[7] = ~btn_raw[7];
      tick();
    end
    btn_raw = '0;
    tick(8);

    // random: mostly-stable buttons with occasional flips, en drops, resets
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(7) == 0) btn_raw[c] = ~btn_raw[c];
      en = ($urandom_range(9) != 0);
      if ($urandom_range(199) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check();
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_button_debounce.md
Name: mole_button_debounce

Overview:
Conditions the nine breadboard push buttons before the whack-a-mole game core sees them. Each raw input passes through a 2-flop synchronizer and then a per-channel debounce FSM. The block outputs a clean level, a one-cycle press pulse and a one-cycle release pulse per button. The game core uses btn_press[i] as the only "hit" event, which replaces its inline time_deb/s_reg logic.

Parameters:
N_BTN, 9, number of button channels (one per mole LED)
DEBOUNCE_CYCLES, 100000, consecutive stable samples needed to accept a change (2 ms at 50 MHz); legal range 2..2^CNT_W-1
CNT_W, 17, width of each per-channel stability counter
ACTIVE_HIGH, 1, 1: raw 1 = pressed; 0: raw 0 = pressed (inverted after synchronizer)

Ports:
cin  input  1  system clock, 50 MHz, all logic on posedge
rst  input  1  asynchronous, active-high reset
btn_raw  input  N_BTN  asynchronous raw button pins
en  input  1  1: press/release pulses allowed; 0: pulses suppressed, state tracking continues
btn_level  output  N_BTN  debounced pressed level
btn_press  output  N_BTN  one-cycle pulse on accepted press
btn_release  output  N_BTN  one-cycle pulse on accepted release
any_press  output  1  OR of btn_press, same cycle

Behaviour:
- Reset (async assert, sync-to-clock deassert by the system): sync flops = inactive, every FSM = RELEASED, counters = 0, all outputs = 0.
- Synchronizer: s1 <= raw (polarity-corrected), s2 <= s1. The FSM samples only s2.
- Per-channel FSM states: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
- RELEASED: if s2 = 1, go to PRESS_PEND with cnt = 1; otherwise stay.
- PRESS_PEND: if s2 = 0, go to RELEASED with cnt = 0 (bounce rejected, no pulse). If s2 = 1 and cnt = DEBOUNCE_CYCLES-1, go to PRESSED, set btn_level = 1, pulse btn_press for 1 cycle (gated by en), cnt = 0. Otherwise cnt++.
- PRESSED: if s2 = 0, go to RELEASE_PEND with cnt = 1.
- RELEASE_PEND: mirror of PRESS_PEND. On acceptance, go to RELEASED, btn_level = 0, pulse btn_release (gated by en). A bounce back to 1 returns the FSM to PRESSED with no pulse.
- Latency: raw held stable from before edge e0 gives btn_press/btn_level high in the cycle after edge e(DEBOUNCE_CYCLES+1). Total is DEBOUNCE_CYCLES+2 clock edges.
- btn_press and btn_release are registered outputs. Each is high for exactly 1 cycle per accepted transition. Holding a button never re-pulses.
- en: sampled in the acceptance cycle only. A press accepted while en = 0 is lost and is not replayed when en rises. btn_level is never gated.
- Channels are fully independent. Simultaneous presses on several channels give simultaneous pulses, and any_press = 1 for that one cycle.
- Counter never wraps: it saturates at DEBOUNCE_CYCLES-1 by construction, because acceptance resets it.
- Reset mid-pending or mid-pressed: outputs clear immediately. A button still held after reset release must pass a full debounce again, then produces a fresh btn_press.
- Inputs changing every cycle never produce a pulse.

Decomposition:
- Package mole_pkg: the state typedef {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND}, constant N_MOLES = 9, and CLK_HZ = 50_000_000. The game core also uses N_MOLES.
- Sub-module debounce_channel: synchronizer, FSM, counter and pulse regs for one button, parameterized by DEBOUNCE_CYCLES/CNT_W/ACTIVE_HIGH.
- Top generate-loops N_BTN instances and ORs btn_press into any_press.

Test Plan:
(All tests use DEBOUNCE_CYCLES = 4 unless stated.)
- Clean press: btn_raw[3] rises and is held -> btn_press[3] = 1 for exactly 1 cycle, 6 edges later; btn_level[3] = 1 and stays high while held; all other bits 0.
- Bounce rejection: btn_raw[0] toggles 1,1,0,1,1,1,0 per cycle, then held at 1 -> no pulse during the toggling; exactly one btn_press[0] once 4 consecutive synced 1s are seen.
- Release: after the press is accepted, btn_raw[3] drops -> btn_release[3] pulses once, 6 edges later; btn_level[3] = 0; no btn_press.
- Simultaneous: btn_raw = 9'h1FF at the same edge -> btn_press = 9'h1FF and any_press = 1 in the same single cycle.
- en gating: en = 0 while btn_raw[5] is pressed -> btn_level[5] = 1 and no btn_press[5]. Raising en while still held -> still no pulse.
- Reset mid-press: assert rst while in PRESS_PEND with btn_raw[2] held -> all outputs 0 at once. After deassert, btn_press[2] arrives 6 edges later.
